// File: rtl/expand_pkg.sv
// expand_pkg: shared types, sizes and the unsigned-8 saturation helper for
// the EXPAND block. The optional bias path is enabled with EXPAND_BIAS_EN.
package expand_pkg;

  localparam int DIM    = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Clamp a signed 10-bit sum into the unsigned range 0..255.
  function automatic logic [DATA_W-1:0] sat_u8(input logic signed [SUM_W-1:0] sum);
    logic [DATA_W-1:0] res;
    if (sum < 10'sd0) begin
      res = 8'd0;
    end else if (sum > 10'sd255) begin
      res = 8'd255;
    end else begin
      res = sum[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/expand_row_gen.sv
// expand_row_gen: builds one DIM-wide row from the captured vector. Without
// EXPAND_BIAS_EN the row is a plain copy of the vector; with it, the row's
// signed bias is added to every column and the result saturated to 0..255.
module expand_row_gen
  import expand_pkg::*;
(
  input  logic [DIM-1:0][DATA_W-1:0] vec_i,
`ifdef EXPAND_BIAS_EN
  input  logic [DATA_W-1:0]          bias_i,
`endif
  output logic [DIM-1:0][DATA_W-1:0] row_o
);

`ifdef EXPAND_BIAS_EN
  logic signed [SUM_W-1:0] sum_s [DIM];
`endif

  // Per-column element: replicate, or zero-extend + sign-extend, add, saturate.
  always_comb begin
    row_o = '0;
    for (int c = 0; c < DIM; c++) begin
`ifdef EXPAND_BIAS_EN
      sum_s[c] = $signed({2'b00, vec_i[c]}) + $signed({{2{bias_i[DATA_W-1]}}, bias_i});
      row_o[c] = sat_u8(sum_s[c]);
`else
      row_o[c] = vec_i[c];
`endif
    end
  end

endmodule

// File: rtl/expand.sv
// expand: on an enable request, captures a DIM-element vector (plus per-row
// bias when EXPAND_BIAS_EN is defined) and writes it row by row into a
// DIMxDIM output matrix, one row per cycle, then pulses done for one cycle.
// Dropping enable during LOAD/FILL abandons the run, keeping rows written.
module expand
  import expand_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [DIM-1:0][DATA_W-1:0]           vector_in,
`ifdef EXPAND_BIAS_EN
  input  logic [DIM-1:0][DATA_W-1:0]           bias_in,
`endif
  output logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  matrix_out,
  output logic                                 busy,
  output logic                                 done
);

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    row_cnt_q, row_cnt_d;
  logic [DIM-1:0][DATA_W-1:0]          vec_q, vec_d;
  logic [DIM-1:0][DIM-1:0][DATA_W-1:0] matrix_q, matrix_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic [DIM-1:0][DATA_W-1:0]          row_s;

`ifdef EXPAND_BIAS_EN
  logic [DIM-1:0][DATA_W-1:0]          bias_q, bias_d;

  expand_row_gen u_row_gen (
    .vec_i  (vec_q),
    .bias_i (bias_q[row_cnt_q]),
    .row_o  (row_s)
  );
`else
  expand_row_gen u_row_gen (
    .vec_i  (vec_q),
    .row_o  (row_s)
  );
`endif

  // Next-state, capture, row write and handshake decode.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    vec_d     = vec_q;
    matrix_d  = matrix_q;
    done_d    = 1'b0;
`ifdef EXPAND_BIAS_EN
    bias_d    = bias_q;
`endif
    case (state_q)
      IDLE: begin
        row_cnt_d = 4'd0;
        if (enable) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        row_cnt_d = 4'd0;
        if (enable) begin
          vec_d   = vector_in;
`ifdef EXPAND_BIAS_EN
          bias_d  = bias_in;
`endif
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (enable) begin
          matrix_d[row_cnt_q] = row_s;
          if (row_cnt_q == 4'd15) begin
            row_cnt_d = 4'd0;
            state_d   = DONE;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end else begin
          row_cnt_d = 4'd0;
          state_d   = IDLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        row_cnt_d = 4'd0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == FILL);
  end

  // State, counter, captured operands and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= 4'd0;
      vec_q     <= '0;
      matrix_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef EXPAND_BIAS_EN
      bias_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      vec_q     <= vec_d;
      matrix_q  <= matrix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef EXPAND_BIAS_EN
      bias_q    <= bias_d;
`endif
    end
  end

  assign matrix_out = matrix_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_expand.sv
// tb_expand: randomized bench for expand with a cycle-indexed reference model.
// Covers EXPAND_BIAS_EN when the macro is defined for the build.
module tb_expand;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic [15:0][7:0]       vector_in;
  logic [15:0][7:0]       bias_in;
  logic [15:0][15:0][7:0] matrix_out;
  logic                   busy;
  logic                   done;

  int n_vec;
  int n_err;

  // Reference state: captured operands as plain integers and expected matrix.
  int cap_vec  [16];
  int cap_bias [16];
  int exp_m    [16][16];

  expand dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vector_in  (vector_in),
`ifdef EXPAND_BIAS_EN
    .bias_in    (bias_in),
`endif
    .matrix_out (matrix_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_elem(input int r, input int c);
    int s;
`ifdef EXPAND_BIAS_EN
    s = cap_vec[c] + cap_bias[r];
    if (s < 0) s = 0;
    if (s > 255) s = 255;
`else
    s = cap_vec[c];
`endif
    return s;
  endfunction

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) v[c*8 +: 8] = 8'(exp_m[r][c]);
    return v;
  endfunction

  task automatic check_rows(input string what, input int k);
    for (int r = 0; r < 16; r++)
      check_eq($sformatf("%s_row%0d_k%0d", what, r, k), matrix_out[r], exp_row(r));
  endtask

  task automatic clear_model();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) exp_m[r][c] = 0;
  endtask

  task automatic scramble_inputs();
    for (int c = 0; c < 16; c++) begin
      vector_in[c] = 8'($urandom_range(255, 0));
      bias_in[c]   = 8'($urandom_range(255, 0));
    end
  endtask

  // One request starting in cycle 0 (state IDLE). a: cycle enable drops (0 = never).
  // rc: cycle reset is asserted (0 = never). chain: keep enable at cycle 19.
  // mode 0 random, 1 replication pattern, 2 saturation pattern.
  task automatic run(input int a, input int rc, input bit chain, input int mode);
    for (int c = 0; c < 16; c++) begin
      case (mode)
        1: begin vector_in[c] = 8'(c * 16 + 1); bias_in[c] = 8'd0; end
        2: begin vector_in[c] = (c == 1) ? 8'd5 : 8'd250; bias_in[c] = 8'd0; end
        default: begin
          vector_in[c] = 8'($urandom_range(255, 0));
          bias_in[c]   = 8'($urandom_range(255, 0));
        end
      endcase
    end
    if (mode == 2) begin
      bias_in[0] = 8'd10;
      bias_in[1] = 8'h80;
    end
    for (int c = 0; c < 16; c++) begin
      cap_vec[c]  = int'(vector_in[c]);
      cap_bias[c] = int'($signed(bias_in[c]));
    end
    enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1;
      if ((k - 1) >= 2 && (k - 1) <= 17 && (a == 0 || (k - 1) < a))
        for (int c = 0; c < 16; c++) exp_m[k - 3][c] = ref_elem(k - 3, c);
      if (rc != 0 && k == rc) begin
        rst = 1'b0;
        enable = 1'b0;
        #1;
        clear_model();
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_rows("rst", k);
        @(posedge clk);
        #1;
        check_eq("rst_hold_done", 128'(done), 128'd0);
        check_rows("rsthold", k);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_busy", 128'(busy), 128'd0);
        check_eq("post_rst_done", 128'(done), 128'd0);
        return;
      end
      check_eq($sformatf("busy_k%0d", k), 128'(busy),
               128'((k <= 17) && (a == 0 || k <= a)));
      check_eq($sformatf("done_k%0d", k), 128'(done), 128'((k == 19) && (a == 0)));
      check_rows("run", k);
      if (a != 0 && k == a) enable = 1'b0;
      if (a != 0 && k >= a + 2) return;
      if (k >= 2) begin
        if (mode == 1) begin
          for (int c = 0; c < 16; c++) vector_in[c] = 8'hFF;
        end else begin
          scramble_inputs();
        end
      end
      if (a == 0 && k == 18) enable = 1'($urandom_range(1, 0));
      if (a == 0 && k == 19) begin
        enable = chain;
        if (chain) return;
      end
      if (k == 20) return;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    enable = 1'b0;
    vector_in = '0;
    bias_in = '0;
    clear_model();
    #2;
    check_eq("reset_busy", 128'(busy), 128'd0);
    check_eq("reset_done", 128'(done), 128'd0);
    check_rows("reset", 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_busy", 128'(busy), 128'd0);
    check_eq("idle_done", 128'(done), 128'd0);

    run(8, 0, 1'b0, 0);
    run(0, 0, 1'b0, 1);
    run(0, 0, 1'b1, 0);
    run(0, 0, 1'b0, 0);
    run(0, 10, 1'b0, 0);
`ifdef EXPAND_BIAS_EN
    run(0, 0, 1'b0, 2);
    check_eq("sat_hi", 128'(matrix_out[0][0]), 128'd255);
    check_eq("sat_lo", 128'(matrix_out[1][1]), 128'd0);
`endif

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(3, 0))
        0: run($urandom_range(17, 1), 0, 1'b0, 0);
        1: run(0, $urandom_range(18, 1), 1'b0, 0);
        2: begin
          run(0, 0, 1'b1, 0);
          run(0, 0, 1'b0, 0);
        end
        default: run(0, 0, 1'b0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
